// File: rtl/branch_predictor.sv
// Branch predictor: table of 2-bit saturating counters indexed by pc[IW:1], plus a saturating mispredict counter.
// Latency: predict_taken is combinational from lookup_pc; updates are visible from the cycle after the update edge.
// Backpressure: none; one update per cycle is always accepted. Optional macro BP_BYPASS_EN forwards a same-index update to the prediction.
module branch_predictor #(
    parameter int         ENTRIES    = 16,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lookup_pc,
    output logic        predict_taken,
    input  logic        update_en,
    input  logic [15:0] update_pc,
    input  logic        update_taken,
    input  logic        update_mispredict,
    output logic [15:0] mispredict_count
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [1:0]    cnt_q [ENTRIES];
    logic [IW-1:0] lookup_idx;
    logic [IW-1:0] update_idx;
    logic [1:0]    update_cur;
    logic [1:0]    update_next;
    logic          same_idx;

    // pc[0] is always zero for 16-bit aligned fetch and upper bits alias, so only pc[IW:1] selects an entry
    assign lookup_idx = lookup_pc[IW:1];
    assign update_idx = update_pc[IW:1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[15:IW+1], lookup_pc[0], update_pc[15:IW+1], update_pc[0]};

    // Next value of the entry being trained: step toward the actual outcome, saturating at both ends
    always_comb begin
        update_cur  = cnt_q[update_idx];
        update_next = update_cur;
        if (update_taken) begin
            if (update_cur != 2'b11) begin
                update_next = update_cur + 2'b01;
            end
        end else begin
            if (update_cur != 2'b00) begin
                update_next = update_cur - 2'b01;
            end
        end
    end

    // Forwarding only applies to an update that will actually land, so reset suppresses it
    assign same_idx = update_en && !rst && (update_idx == lookup_idx);

    // Prediction is the MSB of the selected counter; bypass build substitutes the in-flight value on an index hit
    always_comb begin
        predict_taken = cnt_q[lookup_idx][1];
`ifdef BP_BYPASS_EN
        if (same_idx) begin
            predict_taken = update_next[1];
        end
`endif
    end

`ifndef BP_BYPASS_EN
    logic unused_same_idx;
    assign unused_same_idx = same_idx;
`endif

    // Counter table: reset wins over an update in the same cycle; otherwise only the addressed entry moves
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= INIT_STATE;
            end
        end else if (update_en) begin
            cnt_q[update_idx] <= update_next;
        end
    end

    // Mispredict statistics counter, sticks at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_count <= 16'h0000;
        end else if (update_en && update_mispredict && (mispredict_count != 16'hFFFF)) begin
            mispredict_count <= mispredict_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default ENTRIES=16, INIT_STATE=01).
// Inputs change #1 after a rising edge or at the falling edge; outputs are sampled 1ns later.
// Expected values are hand-derived counter sequences; the bypass case follows BP_BYPASS_EN.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [15:0] lookup_pc;
    logic        predict_taken;
    logic        update_en;
    logic [15:0] update_pc;
    logic        update_taken;
    logic        update_mispredict;
    logic [15:0] mispredict_count;

    int vectors     = 0;
    int miscompares = 0;

    branch_predictor #(.ENTRIES(16), .INIT_STATE(2'b01)) dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .update_en         (update_en),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One update cycle: drive, take one rising edge, then release update_en
    task automatic upd(input logic [15:0] pc, input logic t, input logic m);
        update_en         = 1'b1;
        update_pc         = pc;
        update_taken      = t;
        update_mispredict = m;
        @(posedge clk);
        #1;
        update_en         = 1'b0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            lookup_pc = 16'(i * 2);
            #1;
            vectors++;
            if (predict_taken !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_pred idx=%0d got=%b exp=0", i, predict_taken);
            end
        end
        vectors++;
        if (mispredict_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_count got=%h exp=0000", mispredict_count);
        end
    endtask

    task automatic test_increment();
        logic exp_seq [3];
        exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lookup_pc = 16'h0010;
            upd(16'h0004, 1'b1, 1'b0);
            @(negedge clk);
            lookup_pc = 16'h0004;
            #1;
            vectors++;
            if (predict_taken !== exp_seq[k]) begin
                miscompares++;
                $display("FAIL inc_pred step=%0d got=%b exp=%b", k, predict_taken, exp_seq[k]);
            end
        end
        @(negedge clk);
        lookup_pc = 16'h0024;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL inc_alias_0024 got=%b exp=1", predict_taken);
        end
        @(negedge clk);
        lookup_pc = 16'h0005;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL inc_alias_0005 got=%b exp=1", predict_taken);
        end
        @(negedge clk);
        lookup_pc = 16'h0006;
        #1;
        vectors++;
        if (predict_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL inc_neighbour got=%b exp=0", predict_taken);
        end
    endtask

    task automatic test_decrement();
        // 11 -> NT 10 -> NT 01 -> NT 00 -> NT 00 -> T 01 -> T 10
        logic tk  [6];
        logic exp [6];
        tk[0] = 1'b0; exp[0] = 1'b1;
        tk[1] = 1'b0; exp[1] = 1'b0;
        tk[2] = 1'b0; exp[2] = 1'b0;
        tk[3] = 1'b0; exp[3] = 1'b0;
        tk[4] = 1'b1; exp[4] = 1'b0;
        tk[5] = 1'b1; exp[5] = 1'b1;
        @(negedge clk);
        lookup_pc = 16'h0004;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL dec_start got=%b exp=1", predict_taken);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            lookup_pc = 16'h0000;
            upd(16'h0004, tk[k], 1'b0);
            @(negedge clk);
            lookup_pc = 16'h0004;
            #1;
            vectors++;
            if (predict_taken !== exp[k]) begin
                miscompares++;
                $display("FAIL dec_pred step=%0d got=%b exp=%b", k, predict_taken, exp[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic exp_same;
`ifdef BP_BYPASS_EN
        exp_same = 1'b1;
`else
        exp_same = 1'b0;
`endif
        @(negedge clk);
        lookup_pc         = 16'h0008;
        update_pc         = 16'h0008;
        update_taken      = 1'b1;
        update_mispredict = 1'b0;
        update_en         = 1'b1;
        #1;
        vectors++;
        if (predict_taken !== exp_same) begin
            miscompares++;
            $display("FAIL bypass_same_cycle got=%b exp=%b", predict_taken, exp_same);
        end
        @(posedge clk);
        #1;
        update_en    = 1'b0;
        update_taken = 1'b0;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_next_cycle got=%b exp=1", predict_taken);
        end
    endtask

    task automatic test_independent();
        // Update index 6 while looking up index 5; both start at 01
        @(negedge clk);
        lookup_pc         = 16'h000A;
        update_pc         = 16'h000C;
        update_taken      = 1'b1;
        update_en         = 1'b1;
        #1;
        vectors++;
        if (predict_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL indep_lookup got=%b exp=0", predict_taken);
        end
        @(posedge clk);
        #1;
        update_en    = 1'b0;
        update_taken = 1'b0;
        @(negedge clk);
        lookup_pc = 16'h000C;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL indep_updated got=%b exp=1", predict_taken);
        end
        @(negedge clk);
        lookup_pc = 16'h000A;
        #1;
        vectors++;
        if (predict_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL indep_other got=%b exp=0", predict_taken);
        end
    endtask

    task automatic test_en_low();
        @(negedge clk);
        update_en         = 1'b0;
        update_pc         = 16'h000A;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;
        lookup_pc         = 16'h000A;
        repeat (3) @(posedge clk);
        #1;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
        vectors++;
        if (predict_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL en_low_pred got=%b exp=0", predict_taken);
        end
        vectors++;
        if (mispredict_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL en_low_count got=%h exp=0000", mispredict_count);
        end
    endtask

    task automatic test_mispredict();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            upd(16'h001E, 1'b1, 1'b1);
        end
        vectors++;
        if (mispredict_count !== 16'h0003) begin
            miscompares++;
            $display("FAIL misp_three got=%h exp=0003", mispredict_count);
        end
        @(negedge clk);
        upd(16'h001E, 1'b1, 1'b0);
        vectors++;
        if (mispredict_count !== 16'h0003) begin
            miscompares++;
            $display("FAIL misp_no_flag got=%h exp=0003", mispredict_count);
        end
        // Preload to FFFE: 65531 more back-to-back mispredicts
        @(negedge clk);
        update_pc         = 16'h001E;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;
        update_en         = 1'b1;
        repeat (65531) @(posedge clk);
        #1;
        update_en         = 1'b0;
        update_mispredict = 1'b0;
        vectors++;
        if (mispredict_count !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL misp_preload got=%h exp=fffe", mispredict_count);
        end
        @(negedge clk);
        upd(16'h001E, 1'b1, 1'b1);
        vectors++;
        if (mispredict_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL misp_reach_max got=%h exp=ffff", mispredict_count);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            upd(16'h001E, 1'b1, 1'b1);
        end
        vectors++;
        if (mispredict_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL misp_saturate got=%h exp=ffff", mispredict_count);
        end
        @(negedge clk);
        update_mispredict = 1'b1;
        update_en         = 1'b0;
        @(posedge clk);
        #1;
        update_mispredict = 1'b0;
        vectors++;
        if (mispredict_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL misp_en_low got=%h exp=ffff", mispredict_count);
        end
    endtask

    task automatic test_reset_priority();
        // Entry at pc 0x0004 is 10; one taken update brings it to 11
        @(negedge clk);
        upd(16'h0004, 1'b1, 1'b0);
        @(negedge clk);
        lookup_pc = 16'h0004;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL rstpri_pre got=%b exp=1", predict_taken);
        end
        @(negedge clk);
        rst = 1'b1;
        upd(16'h0004, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        vectors++;
        if (predict_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpri_pred_in_rst got=%b exp=0", predict_taken);
        end
        vectors++;
        if (mispredict_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL rstpri_count got=%h exp=0000", mispredict_count);
        end
        rst = 1'b0;
        @(negedge clk);
        lookup_pc = 16'h001E;
        #1;
        vectors++;
        if (predict_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpri_other_entry got=%b exp=0", predict_taken);
        end
        // One taken step from 01 must reach 10, proving reset left 01 and not 00
        @(negedge clk);
        lookup_pc = 16'h0000;
        upd(16'h0004, 1'b1, 1'b0);
        @(negedge clk);
        lookup_pc = 16'h0004;
        #1;
        vectors++;
        if (predict_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL rstpri_init_state got=%b exp=1", predict_taken);
        end
    endtask

    initial begin
        rst               = 1'b1;
        lookup_pc         = 16'h0000;
        update_en         = 1'b0;
        update_pc         = 16'h0000;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;

        test_reset();
        test_increment();
        test_decrement();
        test_bypass();
        test_independent();
        test_en_low();
        test_mispredict();
        test_reset_priority();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
